prog_mem: RTL and testbench
===========================

# prog_mem

Parametrised, run-time loadable instruction memory for the 16-bit pMIPS core. It replaces the hard-coded per-program instruction ROMs: the fetch stage reads it with a registered, one-cycle-latency port, and a byte-wide loader port (UART/debug front end) downloads a new program without resynthesis. A two-state controller (RUN/LOAD) arbitrates between fetch and download.

## Interface
- WORD_W, 16, instruction width in bits; must be a multiple of 8
- ADDR_W, 16, width of the byte address from the PC
- DEPTH_LOG2, 3, log2 of word count (default 8 words)

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- iaddr  in  ADDR_W  byte address from PC; bit 0 ignored
- ird  in  1  fetch request
- idata  out  WORD_W  fetched instruction, registered
- ivalid  out  1  idata updated this cycle
- ld_start  in  1  enter LOAD, clear pointer, byte count and overflow flag
- ld_byte  in  8  download byte
- ld_we  in  1  ld_byte strobe
- ld_end  in  1  leave LOAD
- loading  out  1  high in LOAD
- ld_ptr  out  DEPTH_LOG2  next word index to be written
- ld_overflow  out  1  sticky; set when the pointer wraps

## Operation
- Storage: DEPTH = 2^DEPTH_LOG2 words. Contents are zero at configuration and are not cleared by reset.
- Reset values: state RUN, idata 0, ivalid 0, loading 0, ld_ptr 0, ld_overflow 0, byte counter 0, assembly register 0.
- RUN, fetch:
  - Word index is iaddr[DEPTH_LOG2:1].
  - If iaddr[ADDR_W-1:DEPTH_LOG2+1] is nonzero, the address is out of range and the fetch returns 0.
  - ird=0 gives ivalid=0 and idata holds its previous value.
  - ld_we and ld_end are ignored in RUN.
- RUN→LOAD on ld_start.
- LOAD, download:
  - Each ld_we adds one byte, big-endian: the first byte of a word goes to bits [WORD_W-1:WORD_W-8].
  - After WORD_W/8 bytes, the word is written to mem[ld_ptr], ld_ptr increments and the byte counter clears.
  - When ld_ptr wraps from DEPTH-1 to 0, ld_overflow is set. Later words overwrite from word 0.
  - ivalid is held 0 and ird is ignored.
- LOAD→RUN on ld_end.
  - A byte strobed in the same cycle as ld_end is processed first.
  - A partial word left over is discarded and the byte counter clears.
  - ld_ptr and ld_overflow hold until the next ld_start or reset.
- Simultaneous events:
  - ld_start and ld_end together: ld_start wins, giving (re)entry to LOAD.
  - ld_start in LOAD restarts the load: pointer, counter and flag are cleared. ld_we in the same cycle as ld_start is ignored.
- Reset mid-load: returns to RUN with all outputs at reset values. Completed words stay written; the partial word is lost.

## Timing
- Fetch latency: ird/iaddr sampled at edge t drive idata/ivalid after edge t+1. Back-to-back fetches give one word per cycle.
- Load write: the final byte of a word strobed at edge t is written at edge t. ld_ptr shows the new value after t+1.
- Mode change: ld_start or ld_end at t changes loading after t+1. The first accepted fetch is at t+1 and returns data written up to and including t.
- No read-during-write hazard: writes occur only in LOAD and reads only in RUN.

## Test plan
- Reset, then ird=1 with iaddr=0 → after one cycle ivalid=1, idata=0x0000. Reset values hold on all outputs.
- Start a load and send bytes 60 83 60 C3 61 88, then ld_end. Fetch iaddr=0,2,4 → 0x6083, 0x60C3, 0x6188, one per cycle after one-cycle latency, with ld_ptr=3. Fetch iaddr=1 → 0x6083 (bit 0 ignored).
- Fetch iaddr=0x0010 with DEPTH_LOG2=3 → idata=0, ivalid=1.
- Load 9 words (0x1000…0x1008) → ld_overflow=1, ld_ptr=1. Fetch iaddr=0 → 0x1008, iaddr=2 → 0x1001.
- Send 3 bytes (AA BB CC) with ld_end on the third strobe → word 0 = 0xAABB, word 1 unchanged, ld_ptr=1. Separately, assert ld_start and ld_end together → loading=1.
- Assert reset after 1.5 words downloaded → loading=0, ld_ptr=0, ld_overflow=0. Fetch iaddr=0 returns the completed word; ird during LOAD never raises ivalid.

Source files
------------

// File: rtl/prog_mem.sv
// prog_mem: run-time loadable instruction memory for the 16-bit pMIPS core.
// Latency: fetch idata/ivalid one clock after ird/iaddr; loader byte writes its word on the completing strobe.
// Backpressure: none; fetch is served only in RUN, download only in LOAD, and ird in LOAD is dropped.
// Ports: clock/reset (sync, active-high); iaddr/ird -> idata/ivalid fetch port;
//        ld_start/ld_byte/ld_we/ld_end loader port -> loading/ld_ptr/ld_overflow status.
module prog_mem #(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     iaddr,
    input  logic                  ird,
    output logic [WORD_W-1:0]     idata,
    output logic                  ivalid,
    input  logic                  ld_start,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_we,
    input  logic                  ld_end,
    output logic                  loading,
    output logic [DEPTH_LOG2-1:0] ld_ptr,
    output logic                  ld_overflow
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int NBYTES = WORD_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {ST_RUN = 1'b0, ST_LOAD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [WORD_W-1:0]     idata_q, idata_d;
    logic                  ivalid_q, ivalid_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_W-1:0]     asm_q, asm_d;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [WORD_W-1:0]     mem_wdata;
    logic [WORD_W-1:0]     asm_shift;
    logic                  fetch_in_range;
    logic [DEPTH_LOG2-1:0] fetch_idx;

    // Zero at configuration; deliberately outside the reset domain so a
    // reset does not erase a downloaded program.
    logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

    // Upper address bits beyond the memory's reach must be zero.
    assign fetch_in_range = ((iaddr >> (DEPTH_LOG2 + 1)) == '0);
    assign fetch_idx      = iaddr[DEPTH_LOG2:1];
    // Big-endian assembly: each new byte shifts in at the bottom, so the
    // first byte of a word ends up in the top lane.
    assign asm_shift      = (asm_q << 8) | WORD_W'(ld_byte);

    always_comb begin
        state_d   = state_q;
        idata_d   = idata_q;
        ivalid_d  = 1'b0;
        ptr_d     = ptr_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = asm_shift;

        case (state_q)
            ST_RUN: begin
                if (ird) begin
                    ivalid_d = 1'b1;
                    idata_d  = fetch_in_range ? mem[fetch_idx] : '0;
                end
                if (ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    asm_d   = '0;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    // Restart wins over ld_end and drops any byte in the same cycle.
                    ptr_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                    asm_d = '0;
                end else begin
                    if (ld_we) begin
                        if (cnt_q == CNT_W'(NBYTES - 1)) begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + 1'b1;
                            cnt_d  = '0;
                            asm_d  = '0;
                            if (ptr_q == DEPTH_LOG2'(DEPTH - 1)) begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                            asm_d = asm_shift;
                        end
                    end
                    // Byte above is consumed first; any leftover partial word is dropped.
                    if (ld_end) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        asm_d   = '0;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RUN;
            idata_q  <= '0;
            ivalid_q <= 1'b0;
            ptr_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            asm_q    <= '0;
        end else begin
            state_q  <= state_d;
            idata_q  <= idata_d;
            ivalid_q <= ivalid_d;
            ptr_q    <= ptr_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign idata       = idata_q;
    assign ivalid      = ivalid_q;
    assign loading     = (state_q == ST_LOAD);
    assign ld_ptr      = ptr_q;
    assign ld_overflow = ovf_q;

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed testbench for prog_mem with default parameters.
// Drives inputs and samples outputs 1 ns after each rising clock edge.
// Each scenario task checks its own expected values inline.
module tb_prog_mem;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] iaddr = '0;
    logic        ird = 1'b0;
    logic [15:0] idata;
    logic        ivalid;
    logic        ld_start = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_we = 1'b0;
    logic        ld_end = 1'b0;
    logic        loading;
    logic [2:0]  ld_ptr;
    logic        ld_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    prog_mem #(.WORD_W(16), .ADDR_W(16), .DEPTH_LOG2(3)) dut (
        .clock(clock), .reset(reset), .iaddr(iaddr), .ird(ird), .idata(idata),
        .ivalid(ivalid), .ld_start(ld_start), .ld_byte(ld_byte), .ld_we(ld_we),
        .ld_end(ld_end), .loading(loading), .ld_ptr(ld_ptr), .ld_overflow(ld_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_we = 1'b1; ld_byte = b;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic end_load();
        ld_end = 1'b1;
        tick();
        ld_end = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] a);
        ird = 1'b1; iaddr = a;
        tick();
        ird = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (idata !== 16'h0000) begin n_fail++; $display("FAIL rst_idata: got %h want 0000", idata); end
        n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid: got %b want 0", ivalid); end
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL rst_loading: got %b want 0", loading); end
        n_checks++; if (ld_ptr !== 3'd0) begin n_fail++; $display("FAIL rst_ptr: got %0d want 0", ld_ptr); end
        n_checks++; if (ld_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ld_overflow); end
        fetch(16'h0000);
        n_checks++; if (ivalid !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_vld: got %b want 1", ivalid); end
        n_checks++; if (idata !== 16'h0000) begin n_fail++; $display("FAIL rst_fetch_dat: got %h want 0000", idata); end
    endtask

    task automatic test_load_fetch();
        logic [7:0] prog [6] = '{8'h60, 8'h83, 8'h60, 8'hC3, 8'h61, 8'h88};
        start_load();
        n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL lf_loading: got %b want 1", loading); end
        foreach (prog[i]) send_byte(prog[i]);
        end_load();
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL lf_run: got %b want 0", loading); end
        n_checks++; if (ld_ptr !== 3'd3) begin n_fail++; $display("FAIL lf_ptr: got %0d want 3", ld_ptr); end
        // back-to-back fetches, one word per cycle
        ird = 1'b1; iaddr = 16'h0000; tick();
        n_checks++; if (ivalid !== 1'b1 || idata !== 16'h6083) begin n_fail++; $display("FAIL lf_w0: got %b/%h want 1/6083", ivalid, idata); end
        iaddr = 16'h0002; tick();
        n_checks++; if (ivalid !== 1'b1 || idata !== 16'h60C3) begin n_fail++; $display("FAIL lf_w1: got %b/%h want 1/60c3", ivalid, idata); end
        iaddr = 16'h0004; tick();
        n_checks++; if (ivalid !== 1'b1 || idata !== 16'h6188) begin n_fail++; $display("FAIL lf_w2: got %b/%h want 1/6188", ivalid, idata); end
        iaddr = 16'h0001; tick();
        n_checks++; if (idata !== 16'h6083) begin n_fail++; $display("FAIL lf_bit0: got %h want 6083", idata); end
        ird = 1'b0; iaddr = 16'h0004; tick();
        n_checks++; if (ivalid !== 1'b0 || idata !== 16'h6083) begin n_fail++; $display("FAIL lf_hold: got %b/%h want 0/6083", ivalid, idata); end
    endtask

    task automatic test_out_of_range();
        fetch(16'h0010);
        n_checks++; if (ivalid !== 1'b1 || idata !== 16'h0000) begin n_fail++; $display("FAIL oor_10: got %b/%h want 1/0000", ivalid, idata); end
        fetch(16'h0002);
        fetch(16'h8002);
        n_checks++; if (ivalid !== 1'b1 || idata !== 16'h0000) begin n_fail++; $display("FAIL oor_8002: got %b/%h want 1/0000", ivalid, idata); end
    endtask

    task automatic test_overflow();
        start_load();
        for (int w = 0; w < 9; w++) begin
            send_byte(8'h10);
            send_byte(8'(w));
        end
        end_load();
        n_checks++; if (ld_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ld_overflow); end
        n_checks++; if (ld_ptr !== 3'd1) begin n_fail++; $display("FAIL ovf_ptr: got %0d want 1", ld_ptr); end
        fetch(16'h0000);
        n_checks++; if (idata !== 16'h1008) begin n_fail++; $display("FAIL ovf_w0: got %h want 1008", idata); end
        fetch(16'h0002);
        n_checks++; if (idata !== 16'h1001) begin n_fail++; $display("FAIL ovf_w1: got %h want 1001", idata); end
        fetch(16'h000E);
        n_checks++; if (idata !== 16'h1007) begin n_fail++; $display("FAIL ovf_w7: got %h want 1007", idata); end
    endtask

    task automatic test_partial_end();
        start_load();
        n_checks++; if (ld_overflow !== 1'b0) begin n_fail++; $display("FAIL pe_ovf_clr: got %b want 0", ld_overflow); end
        send_byte(8'hAA);
        send_byte(8'hBB);
        ld_end = 1'b1; send_byte(8'hCC); ld_end = 1'b0;
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL pe_loading: got %b want 0", loading); end
        n_checks++; if (ld_ptr !== 3'd1) begin n_fail++; $display("FAIL pe_ptr: got %0d want 1", ld_ptr); end
        fetch(16'h0000);
        n_checks++; if (idata !== 16'hAABB) begin n_fail++; $display("FAIL pe_w0: got %h want aabb", idata); end
        fetch(16'h0002);
        n_checks++; if (idata !== 16'h1001) begin n_fail++; $display("FAIL pe_w1: got %h want 1001", idata); end
        // start and end together from RUN: start wins
        ld_start = 1'b1; ld_end = 1'b1; tick(); ld_start = 1'b0; ld_end = 1'b0;
        n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL pe_se_run: got %b want 1", loading); end
        // restart in LOAD with a coincident byte: the byte is dropped
        ld_start = 1'b1; ld_end = 1'b1; send_byte(8'h55); ld_start = 1'b0; ld_end = 1'b0;
        n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL pe_se_load: got %b want 1", loading); end
        send_byte(8'h12);
        send_byte(8'h34);
        end_load();
        n_checks++; if (ld_ptr !== 3'd1) begin n_fail++; $display("FAIL pe_restart_ptr: got %0d want 1", ld_ptr); end
        fetch(16'h0000);
        n_checks++; if (idata !== 16'h1234) begin n_fail++; $display("FAIL pe_restart_w0: got %h want 1234", idata); end
    endtask

    task automatic test_reset_midload();
        start_load();
        send_byte(8'hDE);
        send_byte(8'hAD);
        ird = 1'b1; iaddr = 16'h0000; ld_we = 1'b1; ld_byte = 8'hBE; tick();
        ld_we = 1'b0;
        n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rm_ird_in_load: got %b want 0", ivalid); end
        tick();
        n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rm_ird_in_load2: got %b want 0", ivalid); end
        ird = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL rm_loading: got %b want 0", loading); end
        n_checks++; if (ld_ptr !== 3'd0) begin n_fail++; $display("FAIL rm_ptr: got %0d want 0", ld_ptr); end
        n_checks++; if (ld_overflow !== 1'b0) begin n_fail++; $display("FAIL rm_ovf: got %b want 0", ld_overflow); end
        n_checks++; if (idata !== 16'h0000 || ivalid !== 1'b0) begin n_fail++; $display("FAIL rm_out: got %b/%h want 0/0000", ivalid, idata); end
        fetch(16'h0000);
        n_checks++; if (idata !== 16'hDEAD) begin n_fail++; $display("FAIL rm_w0: got %h want dead", idata); end
        fetch(16'h0002);
        n_checks++; if (idata !== 16'h1001) begin n_fail++; $display("FAIL rm_w1: got %h want 1001", idata); end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_out_of_range();
        test_overflow();
        test_partial_end();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
